// File: rtl/note_pkg.sv
// Shared constants for the note tone generator: note indices, base divisor table, FSM encoding.
package note_pkg;

  localparam int unsigned NOTE_W    = 3;
  localparam int unsigned OCT_W     = 2;
  localparam int unsigned TABLE_W   = 18;
  localparam int unsigned NUM_NOTES = 8;
  localparam int unsigned STATE_W   = 2;

  localparam logic [NOTE_W-1:0] DO    = 3'd0;
  localparam logic [NOTE_W-1:0] RE    = 3'd1;
  localparam logic [NOTE_W-1:0] MI    = 3'd2;
  localparam logic [NOTE_W-1:0] FA    = 3'd3;
  localparam logic [NOTE_W-1:0] SOL   = 3'd4;
  localparam logic [NOTE_W-1:0] LA    = 3'd5;
  localparam logic [NOTE_W-1:0] SI    = 3'd6;
  localparam logic [NOTE_W-1:0] DO_HI = 3'd7;

  // Full-period divisors for a 50 MHz clock, lowest octave.
  localparam logic [TABLE_W-1:0] DIV_TABLE [NUM_NOTES] = '{
    18'd191205, 18'd170357, 18'd151685, 18'd143172,
    18'd127551, 18'd113636, 18'd101239, 18'd95602
  };

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/note_div_lut.sv
// Combinational note/octave to effective divisor lookup, with simulation shift and floor clamp.
module note_div_lut
  import note_pkg::*;
#(
  parameter int unsigned CNT_W     = 28,
  parameter int unsigned SIM_SHIFT = 0,
  parameter int unsigned MIN_DIV   = 2
) (
  input  logic [NOTE_W-1:0] note_sel,
  input  logic [OCT_W-1:0]  octave,
  output logic [CNT_W-1:0]  eff_div_c
);

  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] shifted;

  always_comb begin
    base      = CNT_W'(DIV_TABLE[note_sel]);
    shifted   = (base >> SIM_SHIFT) >> octave;
    eff_div_c = (shifted < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : shifted;
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator; the divisor is latched only at period wraps so notes change glitch-free.
module note_tone_gen
  import note_pkg::*;
#(
  parameter int unsigned CNT_W     = 28,
  parameter int unsigned SIM_SHIFT = 0,
  parameter int unsigned MIN_DIV   = 2
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              enable,
  input  logic [NOTE_W-1:0] note_sel,
  input  logic [OCT_W-1:0]  octave,
  output logic              clock_out,
  output logic              period_tick,
  output logic              active
);

  logic [STATE_W-1:0] state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0]   div_act, div_n;
  logic [CNT_W-1:0]   eff_div;
  logic               clock_out_n, tick_n, active_n, wrap;

  note_div_lut #(
    .CNT_W    (CNT_W),
    .SIM_SHIFT(SIM_SHIFT),
    .MIN_DIV  (MIN_DIV)
  ) u_lut (
    .note_sel (note_sel),
    .octave   (octave),
    .eff_div_c(eff_div)
  );

  // RUN and DRAIN count identically; enable only decides what happens at the wrap.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    div_n       = div_act;
    clock_out_n = clock_out;
    tick_n      = 1'b0;
    cnt_inc     = cnt + CNT_W'(1);
    wrap        = (cnt == div_act - CNT_W'(1));
    case (state)
      ST_IDLE: begin
        cnt_n       = '0;
        clock_out_n = 1'b0;
        if (enable) begin
          div_n       = eff_div;
          clock_out_n = 1'b1;
          state_n     = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (wrap) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          if (enable) begin
            div_n       = eff_div;
            clock_out_n = 1'b1;
            state_n     = ST_RUN;
          end else begin
            clock_out_n = 1'b0;
            state_n     = ST_IDLE;
          end
        end else begin
          cnt_n       = cnt_inc;
          clock_out_n = (cnt_inc < (div_act >> 1));
          state_n     = enable ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_n     = ST_IDLE;
        cnt_n       = '0;
        clock_out_n = 1'b0;
      end
    endcase
    active_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      div_act     <= CNT_W'(MIN_DIV);
      clock_out   <= 1'b0;
      period_tick <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      div_act     <= div_n;
      clock_out   <= clock_out_n;
      period_tick <= tick_n;
      active      <= active_n;
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench for note_tone_gen with SIM_SHIFT=14 (do=11, re=10, la=6, do'=5 cycles).
module tb_note_tone_gen;

  typedef struct {
    logic out;
    logic tick;
    logic act;
  } exp_t;

  typedef struct {
    logic [2:0] note;
    logic [1:0] oct;
    int         div;
    int         hi;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] note_sel = 3'd0;
  logic [1:0] octave = 2'd0;
  logic       clock_out, period_tick, active;

  exp_t  sb[$];
  string tag = "init";
  int    checks = 0;
  int    failures = 0;
  int    ticks_seen = 0;
  vec_t  vecs[14];

  note_tone_gen #(
    .CNT_W    (28),
    .SIM_SHIFT(14),
    .MIN_DIV  (2)
  ) dut (
    .clock_in   (clk),
    .reset      (reset),
    .enable     (enable),
    .note_sel   (note_sel),
    .octave     (octave),
    .clock_out  (clock_out),
    .period_tick(period_tick),
    .active     (active)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic o, input logic t, input logic a);
    exp_t e;
    e.out  = o;
    e.tick = t;
    e.act  = a;
    sb.push_back(e);
  endtask

  // n samples of a period of length div starting at cnt=0, high while cnt < hi.
  task automatic push_period(input int div, input int hi, input bit first_tick, input int n);
    for (int k = 0; k < n && k < div; k++)
      push_exp(logic'(k < hi), logic'(first_tick && k == 0), 1'b1);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (period_tick === 1'b1) ticks_seen++;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got out=%0b tick=%0b act=%0b",
               tag, clock_out, period_tick, active);
    end else begin
      e = sb.pop_front();
      if ({clock_out, period_tick, active} !== {e.out, e.tick, e.act}) begin
        failures++;
        $display("FAIL %s @%0t: got out=%0b tick=%0b act=%0b, expected out=%0b tick=%0b act=%0b",
                 tag, $time, clock_out, period_tick, active, e.out, e.tick, e.act);
      end
    end
  endtask

  task automatic drain_sb();
    int guard = 0;
    while (sb.size() > 0 && guard < 2000) begin
      step();
      guard++;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 2'd0, 11, 5};
    vecs[1]  = '{3'd1, 2'd0, 10, 5};
    vecs[2]  = '{3'd2, 2'd0,  9, 4};
    vecs[3]  = '{3'd3, 2'd0,  8, 4};
    vecs[4]  = '{3'd4, 2'd0,  7, 3};
    vecs[5]  = '{3'd5, 2'd0,  6, 3};
    vecs[6]  = '{3'd6, 2'd0,  6, 3};
    vecs[7]  = '{3'd7, 2'd0,  5, 2};
    vecs[8]  = '{3'd0, 2'd1,  5, 2};
    vecs[9]  = '{3'd0, 2'd2,  2, 1};
    vecs[10] = '{3'd0, 2'd3,  2, 1};
    vecs[11] = '{3'd7, 2'd3,  2, 1};
    vecs[12] = '{3'd2, 2'd1,  4, 2};
    vecs[13] = '{3'd1, 2'd2,  2, 1};

    // Two full periods per note/octave, starting from reset.
    for (int i = 0; i < 14; i++) begin
      tag = $sformatf("vec%0d_note%0d_oct%0d", i, vecs[i].note, vecs[i].oct);
      do_reset();
      note_sel = vecs[i].note;
      octave   = vecs[i].oct;
      enable   = 1'b1;
      push_period(vecs[i].div, vecs[i].hi, 1'b0, vecs[i].div);
      push_period(vecs[i].div, vecs[i].hi, 1'b1, vecs[i].div);
      drain_sb();
    end
    octave = 2'd0;

    tag = "mid_change";
    do_reset();
    note_sel = 3'd0;
    enable   = 1'b1;
    push_period(11, 5, 1'b0, 11);
    push_period(6, 3, 1'b1, 6);
    push_period(6, 3, 1'b1, 6);
    repeat (5) step();
    note_sel = 3'd5;
    drain_sb();

    // Temporary mid-period change is ignored; change just before the wrap edge is taken.
    tag = "wrap_change";
    do_reset();
    note_sel = 3'd0;
    enable   = 1'b1;
    push_period(11, 5, 1'b0, 11);
    push_period(5, 2, 1'b1, 5);
    push_period(5, 2, 1'b1, 5);
    repeat (3) step();
    note_sel = 3'd7;
    repeat (5) step();
    note_sel = 3'd0;
    repeat (3) step();
    note_sel = 3'd7;
    drain_sb();

    tag = "drain_stop";
    do_reset();
    note_sel = 3'd0;
    enable   = 1'b1;
    push_period(11, 5, 1'b0, 11);
    push_exp(1'b0, 1'b1, 1'b0);
    repeat (3) push_exp(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    enable = 1'b0;
    drain_sb();

    tag = "drain_resume";
    do_reset();
    enable = 1'b1;
    push_period(11, 5, 1'b0, 11);
    push_period(11, 5, 1'b1, 11);
    repeat (3) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    drain_sb();

    tag = "reset_mid";
    do_reset();
    enable = 1'b1;
    push_period(11, 5, 1'b0, 5);
    repeat (5) step();
    reset = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    push_period(11, 5, 1'b0, 11);
    push_period(11, 5, 1'b1, 1);
    drain_sb();

    tag = "long_run";
    do_reset();
    note_sel   = 3'd7;
    enable     = 1'b1;
    ticks_seen = 0;
    push_period(5, 2, 1'b0, 5);
    repeat (99) push_period(5, 2, 1'b1, 5);
    push_exp(1'b1, 1'b1, 1'b1);
    drain_sb();
    checks++;
    if (ticks_seen != 100) begin
      failures++;
      $display("FAIL long_run_ticks: got %0d pulses, expected 100", ticks_seen);
    end

    enable = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
